// File: rtl/tick_token_source.sv
// -----------------------------------------------------------------------------
// tick_token_source
//
// Turns the slow divided clock from the clock divider into a stream of
// incrementing data tokens on a valid/ready channel. Downstream KPN processes
// then see the slow rate as tokens rather than as a clock.
//
// tick_in is treated as asynchronous data. It passes through a synchronizer,
// and its rising edge becomes a one-cycle tick. Each enabled tick pushes the
// current generator value into a small first-word-fall-through FIFO.
//
// Ports
//   clk_in        system clock; the only clock in the block
//   rst_n_in      asynchronous active-low reset
//   tick_in       divided clock, sampled as data
//   enable_in     1 = turn ticks into tokens, 0 = discard ticks
//   clear_in      synchronous flush of FIFO, generator and overflow flag
//   data_out      head-of-FIFO token (valid while valid_out = 1)
//   valid_out     FIFO non-empty
//   ready_in      downstream accepts data_out this cycle
//   count_out     current FIFO occupancy, 0..DEPTH
//   overflow_out  sticky: a tick was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module tick_token_source #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned START = 0,
    parameter int unsigned STEP  = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     tick_in,
    input  logic                     enable_in,
    input  logic                     clear_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] FULL_V  = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Synchronizer and rising-edge detect.
    // s1/s2 form the two-flop synchronizer. s3 holds the previous s2 value,
    // so s2 & ~s3 is high for exactly one cycle per tick_in rise.
    // ------------------------------------------------------------------
    logic s1_q, s2_q, s3_q;
    logic tick;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tick_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

    // ------------------------------------------------------------------
    // Generator and FIFO state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] gen_q,    gen_d;
    logic             ovf_q,    ovf_d;

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;
    logic mem_we;

    assign push_req = tick & enable_in;
    // valid_out comes from the count register only, so there is no
    // combinational path from ready_in to valid_out.
    assign pop      = valid_out & ready_in;
    assign full     = (count_q == FULL_V);
    // A full FIFO can still take a token when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gen_d    = gen_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;

        if (clear_in) begin
            // Clear takes priority: any push or pop this cycle is discarded.
            // The synchronizer is left alone, so an in-flight tick still lands.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            gen_d    = START_V;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
            // The generator advances on every enabled tick, even when the
            // token is dropped, so the consumer sees a gap in the values.
            if (push_req) begin
                gen_d = gen_q + STEP_V;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gen_q    <= START_V;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gen_q    <= gen_d;
            ovf_q    <= ovf_d;
        end
    end

    // The storage is reset so that data_out reads 0 straight out of reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= gen_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: first-word-fall-through head
    // ------------------------------------------------------------------
    assign data_out     = mem_q[rd_ptr_q];
    assign valid_out    = (count_q != '0);
    assign count_out    = count_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_tick_token_source.sv
module tb_tick_token_source;

    localparam int DEPTH = 4;

    logic       clk_in    = 1'b0;
    logic       rst_n_in  = 1'b0;
    logic       tick_in   = 1'b0;
    logic       enable_in = 1'b0;
    logic       clear_in  = 1'b0;
    logic       ready_in  = 1'b0;

    logic [7:0] data_out;
    logic       valid_out;
    logic [2:0] count_out;
    logic       overflow_out;

    logic [3:0] data2;
    logic       valid2;
    logic [2:0] count2;
    logic       ovf2;

    always #5 clk_in = ~clk_in;

    // Default build: 8-bit tokens starting at 0, step 1.
    tick_token_source #(.WIDTH(8), .DEPTH(DEPTH), .START(0), .STEP(1)) u_dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .tick_in     (tick_in),
        .enable_in   (enable_in),
        .clear_in    (clear_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .count_out   (count_out),
        .overflow_out(overflow_out)
    );

    // Narrow build exercising wrap-around: 14, 3, 8, 13, 2, ...
    tick_token_source #(.WIDTH(4), .DEPTH(DEPTH), .START(14), .STEP(5)) u_wrap (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .tick_in     (tick_in),
        .enable_in   (enable_in),
        .clear_in    (clear_in),
        .data_out    (data2),
        .valid_out   (valid2),
        .ready_in    (ready_in),
        .count_out   (count2),
        .overflow_out(ovf2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: token queues, generator values and the overflow flag.
    int q1[$];
    int q2[$];
    int g1 = 0;
    int g2 = 14;
    bit ov = 1'b0;
    // samp[k] = tick_in seen at clock edge k. Edges before 'base' (reset)
    // read as 0.
    bit samp[$];
    int base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count",    32'(count_out),    32'(q1.size()));
        chk("valid",    32'(valid_out),    32'(q1.size() != 0));
        chk("overflow", 32'(overflow_out), 32'(ov));
        if (q1.size() != 0) chk("data", 32'(data_out), 32'(q1[0]));
        chk("w_count",    32'(count2), 32'(q2.size()));
        chk("w_valid",    32'(valid2), 32'(q2.size() != 0));
        chk("w_overflow", 32'(ovf2),   32'(ov));
        if (q2.size() != 0) chk("w_data", 32'(data2), 32'(q2[0]));
    endtask

    task automatic check_zero();
        chk("rst_count",    32'(count_out),    32'(0));
        chk("rst_valid",    32'(valid_out),    32'(0));
        chk("rst_data",     32'(data_out),     32'(0));
        chk("rst_overflow", 32'(overflow_out), 32'(0));
        chk("rst_w_valid",  32'(valid2),       32'(0));
        chk("rst_w_data",   32'(data2),        32'(0));
    endtask

    // Applies one clock edge to the model using the inputs the DUT saw.
    task automatic model_edge();
        int  n;
        bit  a, b, tk, preq, pop, full;
        samp.push_back(tick_in);
        n = samp.size() - 1;
        if (!rst_n_in) begin
            base = n + 1;
            q1.delete();
            q2.delete();
            g1 = 0;
            g2 = 14;
            ov = 1'b0;
            return;
        end
        // A rise first sampled at edge E0 pushes at E0 + 2.
        a  = (n - 2 >= base) ? samp[n-2] : 1'b0;
        b  = (n - 3 >= base) ? samp[n-3] : 1'b0;
        tk = a & ~b;
        if (clear_in) begin
            q1.delete();
            q2.delete();
            g1 = 0;
            g2 = 14;
            ov = 1'b0;
            return;
        end
        preq = tk & enable_in;
        pop  = (q1.size() != 0) && ready_in;
        full = (q1.size() == DEPTH);
        if (pop) begin
            void'(q1.pop_front());
            void'(q2.pop_front());
        end
        if (preq) begin
            if (!full || pop) begin
                q1.push_back(g1);
                q2.push_back(g2);
            end else begin
                ov = 1'b1;
            end
            g1 = (g1 + 1) % 256;
            g2 = (g2 + 5) % 16;
        end
    endtask

    initial begin
        int tick_left = 6;
        int rp = 100;
        int ep = 100;

        // Hold reset for a few edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            model_edge();
        end
        @(negedge clk_in);
        check_zero();
        rst_n_in = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_in);
            check_outputs();
            rst_n_in = 1'b1;

            // Phases: 0 = free-flowing, 1 = stalled consumer, 2 = ticks
            // disabled, 3 = mixed. The first phase is always free-flowing.
            if (c % 250 == 0) begin
                case ((c == 0) ? 0 : $urandom_range(0, 3))
                    0:       begin rp = 100; ep = 100; end
                    1:       begin rp = 0;   ep = 100; end
                    2:       begin rp = 60;  ep = 0;   end
                    default: begin rp = 50;  ep = 80;  end
                endcase
            end

            // tick_in holds each level for 2..12 cycles.
            tick_left--;
            if (tick_left <= 0) begin
                tick_in   = ~tick_in;
                tick_left = $urandom_range(2, 12);
            end
            ready_in  = ($urandom_range(0, 99) < rp);
            enable_in = ($urandom_range(0, 99) < ep);
            clear_in  = (c > 20) && ($urandom_range(0, 149) == 0);

            // Occasional asynchronous reset between edges.
            if (c > 300 && $urandom_range(0, 799) == 0) begin
                rst_n_in = 1'b0;
                #1;
                check_zero();
            end

            @(posedge clk_in);
            model_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_token_source.md
Name: tick_token_source

Overview:
- Consumes the slow divided clock produced by the clock divider, which free-runs off the 50 MHz board clock.
- Synchronizes that slow clock into the clk_in domain and detects its rising edges.
- On each detected edge, generates an incrementing data token into a small first-word-fall-through FIFO.
- Presents tokens to the downstream KPN process over a valid/ready channel, so KPN processes see the slow rate as tokens rather than as a clock.

Parameters:
- WIDTH, 8, token data width in bits.
- DEPTH, 4, FIFO depth in tokens. Power of 2, at least 2.
- START, 0, token value after reset and after clear.
- STEP, 1, increment applied to the token value per generated tick, modulo 2^WIDTH.

Ports:
- clk_in  input  1  system clock (50 MHz); the only clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- tick_in  input  1  divided clock from the clock divider; treated as asynchronous data, never used as a clock.
- enable_in  input  1  1 = generate tokens on ticks; 0 = ignore ticks.
- clear_in  input  1  synchronous flush of FIFO, generator and overflow flag.
- data_out  output  WIDTH  head-of-FIFO token.
- valid_out  output  1  FIFO non-empty.
- ready_in  input  1  downstream accepts data_out.
- count_out  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_out  output  1  sticky: a tick was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - sync flops s1, s2, s3 = 0; generator value gen = START.
  - FIFO empty: pointers 0, count_out = 0, valid_out = 0, data_out = 0, overflow_out = 0.
- Synchronizer:
  - s1 <= tick_in; s2 <= s1; s3 <= s2.
  - tick = s2 & ~s3.
- Tick latency:
  - First clk_in edge sampling tick_in = 1 is E0.
  - tick is high for exactly one cycle, between E1 and E2.
  - Push occurs at E2; valid_out rises after E2 if the FIFO was empty (3 cycles).
- Tick count: one tick per tick_in rising edge, none on falling edges. tick_in high or low time must be at least 2 clk_in cycles.
- push_req = tick & enable_in. With enable_in = 0, ticks are discarded and gen holds.
- pop = valid_out & ready_in. data_out advances on the next cycle.
- Push accepted when count < DEPTH, or when count == DEPTH and pop occurs in the same cycle.
- On accepted push: write gen to the FIFO; gen <= gen + STEP, wrapping modulo 2^WIDTH.
- On push_req while full without pop:
  - token dropped, FIFO unchanged;
  - gen still advances by STEP, so the consumer sees a value gap;
  - overflow_out <= 1, held until clear or reset.
- Simultaneous push and pop: count_out unchanged, both pointers advance.
- Ordering: tokens leave strictly in generation order. First-word-fall-through: data_out equals the oldest entry whenever valid_out = 1. data_out is don't-care while valid_out = 0 after the first push.
- valid_out = (count_out != 0), registered-derived with no combinational path from ready_in.
- Pointer wrap: read and write pointers wrap modulo DEPTH. count_out ranges 0..DEPTH.
- clear_in = 1 (synchronous):
  - FIFO emptied, gen <= START, overflow_out <= 0;
  - any push or pop that cycle is ignored;
  - sync flops not cleared, so a tick in flight at clear is still generated afterwards, subject to enable_in.
- Reset mid-operation: all state returns to reset values immediately. The first tick after release requires a fresh 0->1 transition seen through s2/s3.

Test Plan:
- Reset, then enable_in = 1, ready_in = 1, tick_in toggling every 10 clk_in cycles -> tokens 0, 1, 2, 3 appear one per tick_in rise, each valid for 1 cycle, first valid_out 3 cycles after the first sampled rise; overflow_out = 0.
- ready_in = 0, 6 tick rises with DEPTH = 4 -> count_out reaches 4; overflow_out = 1 at the 5th tick; then ready_in = 1 -> pops 0, 1, 2, 3; next tick yields 6.
- FIFO full and tick coincides with pop -> push accepted, count_out stays 4, no overflow.
- enable_in = 0 across 3 ticks, then 1 -> no tokens during disable; the next token continues from the held gen value.
- WIDTH = 4, STEP = 5, 4 ticks from START = 14 -> tokens 14, 3, 8, 13 (wrap-around).
- clear_in pulsed with 2 tokens queued and overflow set -> count_out = 0, valid_out = 0, overflow_out = 0; next token = START. rst_n_in asserted mid-stream -> all outputs 0 asynchronously.
